// File: rtl/program_loader.sv
// program_loader
//   Write side of the SIMD instruction memory. Receives a length-prefixed,
//   little-endian byte stream, packs it into instruction words
//   {opcode, a_addr, b_addr, r_addr}, rejects illegal opcodes, writes the
//   accepted words to consecutive addresses and holds the decoder/PC in
//   reset until a whole program has been written.
//
// Ports
//   clk        in   sole clock
//   rstn       in   asynchronous active-low reset
//   start      in   begin a load (honoured in IDLE, DONE, ERR)
//   s_data     in   stream byte
//   s_valid    in   stream byte valid
//   s_ready    out  loader accepts a byte
//   ins_we     out  instruction memory write strobe
//   ins_waddr  out  instruction memory write address
//   ins_wdata  out  instruction word {opcode, a_addr, b_addr, r_addr}
//   core_rstn  out  active-low reset to decoder/PC, high only after a good load
//   done       out  last load completed
//   error      out  last load aborted
//   ins_count  out  instructions written in the current/last load
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | out of reset, waiting for start
// HDR0    | waiting for low byte of instruction count N
// HDR1    | waiting for high byte of N, then range check
// PAYLOAD | collecting the bytes of one instruction word
// CHECK   | opcode legality check on the assembled word
// WRITE   | one-cycle write strobe into instruction memory
// DONE    | program loaded, core released from reset
// ERR     | load aborted (bad length or illegal opcode)

module program_loader #(
    parameter int  INS_ADDR_WIDTH = 10,
    parameter int  ADDR_WIDTH     = 10,
    localparam int OPCODE_WIDTH   = 3,
    localparam int INS_WIDTH      = OPCODE_WIDTH + 3 * ADDR_WIDTH,
    localparam int BYTES_PER_INS  = (INS_WIDTH + 7) / 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [7:0]                s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      ins_we,
    output logic [INS_ADDR_WIDTH-1:0] ins_waddr,
    output logic [INS_WIDTH-1:0]      ins_wdata,
    output logic                      core_rstn,
    output logic                      done,
    output logic                      error,
    output logic [INS_ADDR_WIDTH:0]   ins_count
);

    localparam int BCNT_W = $clog2(BYTES_PER_INS + 1);

    typedef enum logic [2:0] {
        IDLE, HDR0, HDR1, PAYLOAD, CHECK, WRITE, DONE, ERR
    } state_t;

    state_t state_q, state_d;

    logic [15:0]               n_q;
    logic [BCNT_W-1:0]         bcnt_q;
    logic [INS_WIDTH-1:0]      word_q;
    logic [INS_ADDR_WIDTH:0]   count_q;
    logic                      s_ready_q;
    logic                      ins_we_q;
    logic [INS_ADDR_WIDTH-1:0] waddr_q;
    logic [INS_WIDTH-1:0]      wdata_q;
    logic                      core_rstn_q;
    logic                      done_q;
    logic                      error_q;

    logic        xfer;
    logic        start_ok;
    logic [15:0] hdr_n;
    logic        last_byte;
    logic        opcode_ok;
    logic        last_ins;

    assign xfer      = s_valid && s_ready_q;
    assign start_ok  = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign hdr_n     = {s_data, n_q[7:0]};
    assign last_byte = (bcnt_q == BCNT_W'(BYTES_PER_INS - 1));
    assign opcode_ok = (word_q[INS_WIDTH-1 -: OPCODE_WIDTH] <= OPCODE_WIDTH'(5));
    // Compared in 32 bits so N = 2^INS_ADDR_WIDTH terminates on the final write.
    assign last_ins  = ((32'(count_q) + 32'd1) == 32'(n_q));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = HDR0;
            HDR0:    if (xfer) state_d = HDR1;
            HDR1: begin
                if (xfer) begin
                    if (hdr_n == 16'd0)
                        state_d = DONE;
                    else if (32'(hdr_n) > (32'd1 << INS_ADDR_WIDTH))
                        state_d = ERR;
                    else
                        state_d = PAYLOAD;
                end
            end
            PAYLOAD: if (xfer && last_byte) state_d = CHECK;
            CHECK:   state_d = opcode_ok ? WRITE : ERR;
            WRITE:   state_d = last_ins ? DONE : PAYLOAD;
            DONE:    if (start) state_d = HDR0;
            ERR:     if (start) state_d = HDR0;
            default: state_d = IDLE;
        endcase
    end

    // Header, byte counter and word assembly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            n_q    <= '0;
            bcnt_q <= '0;
            word_q <= '0;
        end else if (start_ok) begin
            n_q    <= '0;
            bcnt_q <= '0;
            word_q <= '0;
        end else if (xfer) begin
            case (state_q)
                HDR0: n_q[7:0]  <= s_data;
                HDR1: n_q[15:8] <= s_data;
                PAYLOAD: begin
                    // Bits at or above INS_WIDTH in the last byte are dropped.
                    for (int i = 0; i < 8; i++) begin
                        if ((32'(bcnt_q) * 8 + i) < INS_WIDTH)
                            word_q[32'(bcnt_q) * 8 + i] <= s_data[i];
                    end
                    bcnt_q <= last_byte ? '0 : bcnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are registered from the next state so each one is a clean
    // function of the state the FSM is in during that cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_ready_q   <= 1'b0;
            ins_we_q    <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            core_rstn_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            s_ready_q   <= (state_d == HDR0 || state_d == HDR1 || state_d == PAYLOAD);
            ins_we_q    <= (state_d == WRITE);
            core_rstn_q <= (state_d == DONE);
            done_q      <= (state_d == DONE);
            error_q     <= (state_d == ERR);
            if (state_q == CHECK && state_d == WRITE) begin
                waddr_q <= count_q[INS_ADDR_WIDTH-1:0];
                wdata_q <= word_q;
            end
            if (start_ok)
                count_q <= '0;
            else if (state_q == WRITE)
                count_q <= count_q + 1'b1;
        end
    end

    assign s_ready   = s_ready_q;
    assign ins_we    = ins_we_q;
    assign ins_waddr = waddr_q;
    assign ins_wdata = wdata_q;
    assign core_rstn = core_rstn_q;
    assign done      = done_q;
    assign error     = error_q;
    assign ins_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        ins_we;
    logic [9:0]  ins_waddr;
    logic [32:0] ins_wdata;
    logic        core_rstn;
    logic        done;
    logic        error;
    logic [10:0] ins_count;

    program_loader #(.INS_ADDR_WIDTH(10), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .ins_we(ins_we), .ins_waddr(ins_waddr), .ins_wdata(ins_wdata),
        .core_rstn(core_rstn), .done(done), .error(error), .ins_count(ins_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Write log filled by an observer; tests compare it against hand-computed words.
    logic [9:0]  log_addr [0:4095];
    logic [32:0] log_data [0:4095];
    int          n_wr = 0;

    always @(negedge clk) begin
        if (rstn && ins_we) begin
            if (n_wr < 4096) begin
                log_addr[n_wr] = ins_waddr;
                log_data[n_wr] = ins_wdata;
            end
            n_wr = n_wr + 1;
        end
    end

    logic [7:0] n2_bytes [0:11];
    initial begin
        n2_bytes[0] = 8'h02; n2_bytes[1] = 8'h00;
        n2_bytes[2] = 8'h03; n2_bytes[3] = 8'h08; n2_bytes[4] = 8'h10;
        n2_bytes[5] = 8'h00; n2_bytes[6] = 8'h00;
        n2_bytes[7] = 8'h05; n2_bytes[8] = 8'h10; n2_bytes[9] = 8'h00;
        n2_bytes[10] = 8'h40; n2_bytes[11] = 8'h01;
    end

    localparam logic [32:0] W0 = 33'h0_0010_0803;
    localparam logic [32:0] W1 = 33'h1_4000_1005;

    // All stimulus tasks are entered and left on a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_data  = b;
        s_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_byte_timeout byte=%h s_ready never rose", b);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [32:0] w, input int gap);
        logic [39:0] w40;
        w40 = {7'b0, w};
        for (int k = 0; k < 5; k++) send_byte(w40[8*k +: 8], gap);
    endtask

    function automatic logic [32:0] mk(input int i);
        logic [2:0] op;
        op = 3'(i % 6);
        return {op, 10'(i), 10'(~i), 10'(i * 7)};
    endfunction

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_wait_done got done=%b expected 1", name, done);
        end
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_ready, ins_we, ins_waddr, ins_wdata, core_rstn, done, error, ins_count} !== '0) begin
            failures++;
            $display("FAIL reset_held outputs got rdy=%b we=%b a=%h d=%h crst=%b dn=%b er=%b cnt=%0d expected all 0",
                     s_ready, ins_we, ins_waddr, ins_wdata, core_rstn, done, error, ins_count);
        end
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({s_ready, ins_we, ins_waddr, ins_wdata, core_rstn, done, error, ins_count} !== '0) begin
            failures++;
            $display("FAIL reset_release outputs got rdy=%b we=%b crst=%b dn=%b er=%b cnt=%0d expected all 0",
                     s_ready, ins_we, core_rstn, done, error, ins_count);
        end
    endtask

    task automatic test_n2_load();
        int base;
        base = n_wr;
        pulse_start();
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL n2_ready_after_start got %b expected 1", s_ready); end
        for (int i = 0; i < 12; i++) send_byte(n2_bytes[i], 0);
        // CHECK cycle
        checks++;
        if (ins_we !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL n2_check_cycle got we=%b done=%b expected 0 0", ins_we, done);
        end
        @(negedge clk);
        checks++;
        if (ins_we !== 1'b1 || ins_waddr !== 10'd1 || ins_wdata !== W1 || core_rstn !== 1'b0) begin
            failures++;
            $display("FAIL n2_write_cycle got we=%b a=%0d d=%h crst=%b expected 1 1 %h 0",
                     ins_we, ins_waddr, ins_wdata, core_rstn, W1);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || core_rstn !== 1'b1 || ins_we !== 1'b0 || ins_count !== 11'd2 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL n2_done got done=%b crst=%b we=%b cnt=%0d rdy=%b expected 1 1 0 2 0",
                     done, core_rstn, ins_we, ins_count, s_ready);
        end
        checks++;
        if ((n_wr - base) !== 2 || log_addr[base] !== 10'd0 || log_data[base] !== W0 ||
            log_addr[base+1] !== 10'd1 || log_data[base+1] !== W1) begin
            failures++;
            $display("FAIL n2_writes got n=%0d a0=%0d d0=%h a1=%0d d1=%h expected 2 0 %h 1 %h",
                     n_wr - base, log_addr[base], log_data[base], log_addr[base+1], log_data[base+1], W0, W1);
        end
    endtask

    task automatic test_illegal_opcode();
        int base;
        base = n_wr;
        pulse_start();
        checks++;
        if (done !== 1'b0 || core_rstn !== 1'b0 || ins_count !== 11'd0) begin
            failures++; $display("FAIL illegal_start_clear got done=%b crst=%b cnt=%0d expected 0 0 0", done, core_rstn, ins_count);
        end
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_word(33'h1_8000_0000, 0);
        checks++;
        if (error !== 1'b0) begin failures++; $display("FAIL illegal_check_cycle got error=%b expected 0", error); end
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || ins_we !== 1'b0 || s_ready !== 1'b0 || core_rstn !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL illegal_err got er=%b we=%b rdy=%b crst=%b dn=%b expected 1 0 0 0 0",
                     error, ins_we, s_ready, core_rstn, done);
        end
        s_data = 8'h02; s_valid = 1'b1;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if ((n_wr - base) !== 0 || s_ready !== 1'b0 || error !== 1'b1) begin
            failures++; $display("FAIL illegal_no_write got n=%0d rdy=%b er=%b expected 0 0 1", n_wr - base, s_ready, error);
        end
        pulse_start();
        checks++;
        if (error !== 1'b0) begin failures++; $display("FAIL illegal_restart_clear got error=%b expected 0", error); end
        for (int i = 0; i < 12; i++) send_byte(n2_bytes[i], 0);
        wait_done("illegal_reload");
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || (n_wr - base) !== 2 || log_data[base+1] !== W1) begin
            failures++;
            $display("FAIL illegal_reload got dn=%b er=%b n=%0d d1=%h expected 1 0 2 %h", done, error, n_wr - base, log_data[base+1], W1);
        end
    endtask

    task automatic test_length_bounds();
        int base;
        int bad;
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h04, 0);
        checks++;
        if (error !== 1'b1 || s_ready !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL len_1025 got er=%b rdy=%b dn=%b expected 1 0 0", error, s_ready, done);
        end

        base = n_wr;
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h04, 0);
        for (int i = 0; i < 1024; i++) send_word(mk(i), 0);
        wait_done("len_1024");
        @(negedge clk);
        checks++;
        if ((n_wr - base) !== 1024 || ins_count !== 11'd1024 || core_rstn !== 1'b1) begin
            failures++;
            $display("FAIL len_1024_count got n=%0d cnt=%0d crst=%b expected 1024 1024 1", n_wr - base, ins_count, core_rstn);
        end
        bad = -1;
        for (int i = 0; i < 1024; i++) begin
            if (bad < 0 && (log_addr[base+i] !== 10'(i) || log_data[base+i] !== mk(i))) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL len_1024_data at %0d got a=%0d d=%h expected a=%0d d=%h",
                     bad, log_addr[base+bad], log_data[base+bad], bad, mk(bad));
        end

        base = n_wr;
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        checks++;
        if (done !== 1'b1 || core_rstn !== 1'b1 || ins_count !== 11'd0 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL len_zero got dn=%b crst=%b cnt=%0d rdy=%b expected 1 1 0 0", done, core_rstn, ins_count, s_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ((n_wr - base) !== 0) begin failures++; $display("FAIL len_zero_writes got %0d expected 0", n_wr - base); end
    endtask

    task automatic test_flow_control();
        int base;
        base = n_wr;
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            if (i == 6) begin
                pulse_start();
                checks++;
                if (s_ready !== 1'b1 || ins_count !== 11'd0) begin
                    failures++; $display("FAIL flow_mid_start got rdy=%b cnt=%0d expected 1 0", s_ready, ins_count);
                end
            end
            send_byte(n2_bytes[i], int'($urandom_range(0, 3)));
        end
        wait_done("flow");
        checks++;
        if ((n_wr - base) !== 2 || log_addr[base] !== 10'd0 || log_data[base] !== W0 ||
            log_addr[base+1] !== 10'd1 || log_data[base+1] !== W1 || ins_count !== 11'd2) begin
            failures++;
            $display("FAIL flow_writes got n=%0d d0=%h d1=%h cnt=%0d expected 2 %h %h 2",
                     n_wr - base, log_data[base], log_data[base+1], ins_count, W0, W1);
        end
    endtask

    task automatic test_reset_mid_load();
        int base;
        base = n_wr;
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h03, 0); send_byte(8'h08, 0); send_byte(8'h10, 0);
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL midrst_pre got rdy=%b expected 1", s_ready); end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({s_ready, ins_we, ins_waddr, ins_wdata, core_rstn, done, error, ins_count} !== '0) begin
            failures++;
            $display("FAIL midrst_async got rdy=%b we=%b crst=%b dn=%b er=%b cnt=%0d expected all 0",
                     s_ready, ins_we, core_rstn, done, error, ins_count);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ((n_wr - base) !== 0 || s_ready !== 1'b0) begin
            failures++; $display("FAIL midrst_idle got n=%0d rdy=%b expected 0 0", n_wr - base, s_ready);
        end
        pulse_start();
        for (int i = 0; i < 12; i++) send_byte(n2_bytes[i], 0);
        wait_done("midrst_reload");
        checks++;
        if ((n_wr - base) !== 2 || log_addr[base] !== 10'd0 || log_data[base] !== W0 ||
            log_addr[base+1] !== 10'd1 || log_data[base+1] !== W1) begin
            failures++;
            $display("FAIL midrst_writes got n=%0d a0=%0d d0=%h d1=%h expected 2 0 %h %h",
                     n_wr - base, log_addr[base], log_data[base], log_data[base+1], W0, W1);
        end
    endtask

    initial begin
        test_reset();
        test_n2_load();
        test_illegal_opcode();
        test_length_bounds();
        test_flow_control();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
